// File: rtl/uart_rx_frame_ctrl_if.sv
// Bundle of the RX frame sequencer's line, tick and consumer handshake signals.
// master: the receiver drives the received word and its status.
// slave:  the line, tick and ready source that consumes the word.
interface uart_rx_frame_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  baud_tick;
   logic                  rx_in;
   logic                  rx_ready;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_valid;
   logic                  parity_err;
   logic                  frame_err;
   logic                  overrun;
   logic                  busy;

   modport master (
      input  baud_tick, rx_in, rx_ready,
      output rx_data, rx_valid, parity_err, frame_err, overrun, busy
   );

   modport slave (
      output baud_tick, rx_in, rx_ready,
      input  rx_data, rx_valid, parity_err, frame_err, overrun, busy
   );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame sequencer: synchronises rx_in, walks start / data (LSB
// first) / optional parity / stop on oversampled ticks, and hands the word
// out on a valid/ready handshake with parity, framing and overrun flags.
// Optional parity bit: define UART_RX_PARITY_EN. Without it the PARITY state
// and the parity accumulator are absent and parity_err is held 0.
module uart_rx_frame_ctrl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned PARITY_ODD = 0
) (
   input logic                 clk,
   input logic                 rst,
   uart_rx_frame_ctrl_if.master bus
);

   localparam int unsigned TW = $clog2(OVERSAMPLE);
   localparam int unsigned BW = $clog2(DATA_WIDTH);
   localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t                state_q, state_d;
   logic                  sync1_q, rx_s_q;
   logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic                  armed_q, armed_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  frame_err_q, frame_err_d;
   logic                  overrun_q, overrun_d;
   logic                  busy_q, busy_d;
   logic                  hs, deliver;
`ifdef UART_RX_PARITY_EN
   logic                  par_q, par_d;
   logic                  perr_q, perr_d;
   logic                  parity_err_q, parity_err_d;
`endif

   // Next-state, frame walking and delivery/handshake bookkeeping
   always_comb begin
      state_d     = state_q;
      tick_cnt_d  = tick_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      armed_d     = armed_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      frame_err_d = frame_err_q;
      overrun_d   = overrun_q;
      deliver     = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d        = par_q;
      perr_d       = perr_q;
      parity_err_d = parity_err_q;
`endif
      hs = rx_valid_q & bus.rx_ready;

      if (hs) begin
         rx_valid_d = 1'b0;
         overrun_d  = 1'b0;
      end

      if (bus.baud_tick) begin
         case (state_q)
            S_IDLE: begin
               // After a low stop bit the line must be seen high before re-arming
               if (!armed_q) begin
                  if (rx_s_q) armed_d = 1'b1;
               end else if (!rx_s_q) begin
                  state_d    = S_START;
                  tick_cnt_d = '0;
               end
            end
            S_START: begin
               if (tick_cnt_q == HALF_LAST) begin
                  tick_cnt_d = '0;
                  bit_cnt_d  = '0;
                  state_d    = rx_s_q ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
                  par_d      = 1'b0;
`endif
               end else begin
                  tick_cnt_d = tick_cnt_q + TW'(1);
               end
            end
            S_DATA: begin
               if (tick_cnt_q == FULL_LAST) begin
                  tick_cnt_d = '0;
                  shreg_d    = {rx_s_q, shreg_q[DATA_WIDTH-1:1]};
`ifdef UART_RX_PARITY_EN
                  par_d      = par_q ^ rx_s_q;
`endif
                  if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_d = S_PARITY;
`else
                     state_d = S_STOP;
`endif
                  end else begin
                     bit_cnt_d = bit_cnt_q + BW'(1);
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + TW'(1);
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (tick_cnt_q == FULL_LAST) begin
                  tick_cnt_d = '0;
                  perr_d     = rx_s_q ^ par_q ^ 1'(PARITY_ODD);
                  state_d    = S_STOP;
               end else begin
                  tick_cnt_d = tick_cnt_q + TW'(1);
               end
            end
`endif
            S_STOP: begin
               if (tick_cnt_q == FULL_LAST) begin
                  tick_cnt_d = '0;
                  deliver    = 1'b1;
                  armed_d    = rx_s_q;
                  state_d    = S_IDLE;
               end else begin
                  tick_cnt_d = tick_cnt_q + TW'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      // A completed word is accepted only if the output slot is free this cycle
      if (deliver) begin
         if (!rx_valid_q || hs) begin
            rx_data_d   = shreg_d;
            frame_err_d = ~rx_s_q;
            rx_valid_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_d = perr_q;
`endif
         end else begin
            overrun_d = 1'b1;
         end
      end

      busy_d = (state_d != S_IDLE);
   end

   // All state, synchroniser and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sync1_q     <= 1'b1;
         rx_s_q      <= 1'b1;
         tick_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         armed_q     <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q        <= 1'b0;
         perr_q       <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         sync1_q     <= bus.rx_in;
         rx_s_q      <= sync1_q;
         tick_cnt_q  <= tick_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         armed_q     <= armed_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
         par_q        <= par_d;
         perr_q       <= perr_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign bus.rx_data   = rx_data_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.frame_err = frame_err_q;
   assign bus.overrun   = overrun_q;
   assign bus.busy      = busy_q;
`ifdef UART_RX_PARITY_EN
   assign bus.parity_err = parity_err_q;
`else
   // PARITY_ODD has no effect without a parity bit; the flag is constant 0
   assign bus.parity_err = 1'(PARITY_ODD) & 1'b0;
`endif

endmodule
